// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: FSM state encodings and address bit-reversal helper
// shared by the BRAM stream reader.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Reverses the low n bits of v; bits at and above n come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < n) r[5'(i)] = v[5'(n - 1 - i)];
        return r;
    endfunction

endpackage

// File: rtl/bram_stream_reader_skid_fifo2.sv
// stream_skid_fifo2: 2-entry FIFO with a registered head, so the output word
// never depends combinationally on the write data.
module stream_skid_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_dout  = r_head;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_head <= (r_count == 2'd2) ? r_tail : i_din;
                if (r_count == 2'd2 && i_push) r_tail <= i_din;
            end else if (i_push) begin
                if (r_count == 2'd0) r_head <= i_din;
                else r_tail <= i_din;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    // The reader's credit rule must never let a push land on a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_push && !w_pop && r_count == 2'd2));

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks len BRAM addresses from base and streams the words out
// via valid/ready. Define BRAM_RD_BITREV_EN to emit bit-reversed read addresses.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DLEN = 32,
    parameter int HLEN = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [HLEN-1:0] base,
    input  logic [HLEN:0]   len,
    output logic            busy,
    output logic            done,
    output logic [HLEN-1:0] raddr,
    input  logic [DLEN-1:0] rdata,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DLEN-1:0] m_data,
    output logic            m_last
);

    state_t          r_state;
    state_t          w_state_next;
    logic [HLEN-1:0] r_addr;
    logic [HLEN-1:0] r_raddr;
    logic [HLEN:0]   r_len;
    logic [HLEN:0]   r_issued;
    logic [HLEN:0]   r_accepted;
    logic            r_inflight;
    logic            r_inflight_last;
    logic [HLEN-1:0] w_raddr_issue;
    logic [1:0]      w_count;
    logic            w_pop;
    logic            w_issue;
    logic            w_issue_last;
    logic            w_accept_last;

`ifdef BRAM_RD_BITREV_EN
    assign w_raddr_issue = HLEN'(bitrev(32'(r_addr), HLEN));
`else
    assign w_raddr_issue = r_addr;
`endif

    assign w_pop         = m_valid && m_ready;
    assign w_issue_last  = (r_issued + (HLEN+1)'(1)) == r_len;
    assign w_accept_last = (r_accepted + (HLEN+1)'(1)) == r_len;
    // A pop this cycle frees a slot in time for the read issued now to land.
    assign w_issue = (r_state == ST_READ) && (r_issued != r_len) &&
                     ((w_count + {1'b0, r_inflight}) < (2'd2 + {1'b0, w_pop}));

    assign raddr = w_issue ? w_raddr_issue : r_raddr;
    assign busy  = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign done  = (r_state == ST_DONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = (len == '0) ? ST_DONE : ST_READ;
            ST_READ:  if (w_issue && w_issue_last) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_pop && w_accept_last) w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_raddr         <= '0;
            r_len           <= '0;
            r_issued        <= '0;
            r_accepted      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;
            if (r_state == ST_IDLE && start) begin
                r_addr     <= base;
                r_len      <= len;
                r_issued   <= '0;
                r_accepted <= '0;
            end
            if (w_issue) begin
                r_addr   <= r_addr + HLEN'(1);
                r_issued <= r_issued + (HLEN+1)'(1);
                r_raddr  <= w_raddr_issue;
            end
            if (w_pop) r_accepted <= r_accepted + (HLEN+1)'(1);
        end
    end

    stream_skid_fifo2 #(.W(DLEN + 1)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_din   ({r_inflight_last, rdata}),
        .o_dout  ({m_last, m_data}),
        .o_valid (m_valid),
        .o_count (w_count)
    );

endmodule
